imc_wb_slave_if: RTL and testbench

- Wishbone classic slave front-end directly upstream of the SRAM IMC top.
- Converts Caravel wishbone cycles into push strobes for the input and weight buffers, pop strobes for the output buffer, and control/status register access.
- Owns wbs_ack_o and wbs_dat_o.
- Sits between the user-project wishbone port and the IMC buffer/controller interface.

---
 rtl/imc_wb_pkg.sv | 33 +++
 rtl/imc_wb_decode.sv | 33 +++
 rtl/imc_wb_slave_if.sv | 202 ++++++++++++++++++++
 tb/tb_imc_wb_slave_if.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imc_wb_pkg.sv
// Shared definitions for the IMC wishbone slave front-end: FSM states,
// register offsets, decoded-region bit positions and STATUS layout.
package imc_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Register offsets within the 256-byte slave window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_IB     = 8'h08;
  localparam logic [7:0] OFF_WT     = 8'h0C;
  localparam logic [7:0] OFF_OB     = 8'h10;

  // One-hot region vector {ctrl, status, ib, wt, ob, unmapped}
  localparam int REGION_W  = 6;
  localparam int RG_CTRL   = 5;
  localparam int RG_STATUS = 4;
  localparam int RG_IB     = 3;
  localparam int RG_WT     = 2;
  localparam int RG_OB     = 1;
  localparam int RG_UNMAP  = 0;

  // STATUS register layout: {22'b0, err, busy, buf_flags[7:0]}
  localparam int ST_BUSY_BIT = 8;
  localparam int ST_ERR_BIT  = 9;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/imc_wb_decode.sv
// Address decoder: flags a hit in the slave window and classifies the
// offset into a one-hot region. Reads of write-only data ports and writes of
// the read-only data port fall into the unmapped region, so they are acked
// with no side effect.
module imc_wb_decode
  import imc_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic [31:0]         adr,
  input  logic                we,
  output logic                hit,
  output logic [REGION_W-1:0] region
);

  logic [7:0] off;

  // Window compare and offset classification
  always_comb begin
    off    = adr[7:0];
    hit    = (adr[31:8] == BASE_ADDR[31:8]);
    region = '0;
    case (off)
      OFF_CTRL:   region[RG_CTRL]   = 1'b1;
      OFF_STATUS: region[RG_STATUS] = 1'b1;
      OFF_IB:     if (we) region[RG_IB] = 1'b1; else region[RG_UNMAP] = 1'b1;
      OFF_WT:     if (we) region[RG_WT] = 1'b1; else region[RG_UNMAP] = 1'b1;
      OFF_OB:     if (!we) region[RG_OB] = 1'b1; else region[RG_UNMAP] = 1'b1;
      default:    region[RG_UNMAP]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imc_wb_slave_if.sv
// Wishbone classic slave front-end for the SRAM IMC top. Turns bus cycles
// into input/weight buffer pushes, output buffer pops and CTRL/STATUS access.
// Every transfer walks IDLE -> EXEC -> ACK, so ack arrives no earlier than
// the third cycle of a request.
// Optional feature: define IMC_WB_TIMEOUT_EN to bound EXEC stalls to
// TIMEOUT_CYCLES; a timed-out transfer is acked without push/pop, reads
// return ERR_DATA and the sticky STATUS err bit is set.
module imc_wb_slave_if
  import imc_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] ib_wdata,
  output logic        ib_push,
  input  logic        ib_full,
  output logic [31:0] wt_wdata,
  output logic        wt_push,
  input  logic        wt_full,
  input  logic [31:0] ob_rdata,
  output logic        ob_pop,
  input  logic        ob_empty,
  output logic        ctrl_start,
  output logic [2:0]  ctrl_opcode,
  input  logic        imc_busy,
  input  logic [7:0]  buf_flags
);

  state_t              state, state_nxt;
  logic                hit, req;
  logic [REGION_W-1:0] region, region_p0;
  logic                we_p0, sel0_p0;
  logic [31:0]         dat_p0;
  logic [31:0]         rdata_q, rdata_nxt;
  logic [2:0]          opcode_q;
  logic                opcode_ld;
  logic                err_q, err_set, err_clr;
  logic                stall, timeout;
  logic                unused_sel;

  // Only byte lane 0 matters (CTRL); data pushes are always full words.
  assign unused_sel = ^wbs_sel_i[3:1];

  imc_wb_decode #(
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .adr    (wbs_adr_i),
    .we     (wbs_we_i),
    .hit    (hit),
    .region (region)
  );

  assign req = wbs_cyc_i & wbs_stb_i & hit;

`ifdef IMC_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;

  // Stall counter: held at zero outside EXEC so every entry starts fresh
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)            stall_cnt <= '0;
    else if (state != S_EXEC) stall_cnt <= '0;
    else                     stall_cnt <= stall_cnt + 1'b1;
  end

  assign timeout = (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Request capture control: region, direction and lane-0 select
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      region_p0 <= '0;
      we_p0     <= 1'b0;
      sel0_p0   <= 1'b0;
    end else if (state == S_IDLE && req) begin
      region_p0 <= region;
      we_p0     <= wbs_we_i;
      sel0_p0   <= wbs_sel_i[0];
    end
  end

  // Request capture data (outputs derived from it are gated by control)
  always_ff @(posedge wb_clk_i) begin
    if (state == S_IDLE && req) dat_p0 <= wbs_dat_i;
  end

  // Read data: the EXEC cycle that leaves for ACK leaves its value here
  always_ff @(posedge wb_clk_i) begin
    if (state == S_EXEC) rdata_q <= rdata_nxt;
  end

  // Opcode register and sticky timeout error
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      opcode_q <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      if (opcode_ld) opcode_q <= dat_p0[3:1];
      if (err_clr)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  // Next-state and strobe generation
  always_comb begin
    state_nxt  = state;
    ib_push    = 1'b0;
    wt_push    = 1'b0;
    ob_pop     = 1'b0;
    ctrl_start = 1'b0;
    opcode_ld  = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    stall      = 1'b0;
    rdata_nxt  = '0;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!wbs_cyc_i) begin
          state_nxt = S_IDLE;
        end else begin
          if (region_p0[RG_CTRL]) begin
            state_nxt = S_ACK;
            if (we_p0) begin
              if (sel0_p0) begin
                opcode_ld  = 1'b1;
                ctrl_start = dat_p0[0];
              end
            end else begin
              rdata_nxt = {28'd0, opcode_q, imc_busy};
            end
          end else if (region_p0[RG_STATUS]) begin
            state_nxt = S_ACK;
            if (we_p0) begin
              err_clr = 1'b1;
            end else begin
              rdata_nxt[ST_ERR_BIT]         = err_q;
              rdata_nxt[ST_BUSY_BIT]        = imc_busy;
              rdata_nxt[ST_BUSY_BIT-1:0]    = buf_flags;
            end
          end else if (region_p0[RG_IB]) begin
            if (ib_full) stall = 1'b1;
            else begin
              ib_push   = 1'b1;
              state_nxt = S_ACK;
            end
          end else if (region_p0[RG_WT]) begin
            if (wt_full) stall = 1'b1;
            else begin
              wt_push   = 1'b1;
              state_nxt = S_ACK;
            end
          end else if (region_p0[RG_OB]) begin
            if (ob_empty) stall = 1'b1;
            else begin
              ob_pop    = 1'b1;
              rdata_nxt = ob_rdata;
              state_nxt = S_ACK;
            end
          end else begin
            state_nxt = S_ACK;
          end
          if (stall && timeout) begin
            state_nxt = S_ACK;
            err_set   = 1'b1;
            rdata_nxt = we_p0 ? 32'd0 : ERR_DATA;
          end
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign wbs_ack_o   = (state == S_ACK);
  assign wbs_dat_o   = wbs_ack_o ? rdata_q : 32'd0;
  assign ib_wdata    = ib_push ? dat_p0 : 32'd0;
  assign wt_wdata    = wt_push ? dat_p0 : 32'd0;
  assign ctrl_opcode = opcode_q;

endmodule

// File: tb/tb_imc_wb_slave_if.sv
// Self-checking bench for imc_wb_slave_if: directed cases from the feature
// list followed by randomized transfers checked against a transaction-level
// model of the register map (opcode, err bit, expected strobes and latency).
module tb_imc_wb_slave_if;
  localparam int TO = 64;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
`ifdef IMC_WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] ib_wdata, wt_wdata;
  logic        ib_push, wt_push, ob_pop;
  logic        ib_full, wt_full, ob_empty;
  logic [31:0] ob_rdata;
  logic        ctrl_start;
  logic [2:0]  ctrl_opcode;
  logic        imc_busy;
  logic [7:0]  buf_flags;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [2:0] opcode_m = 3'd0;
  logic       err_m = 1'b0;

  always #5 clk = ~clk;

  imc_wb_slave_if dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .ib_wdata    (ib_wdata),
    .ib_push     (ib_push),
    .ib_full     (ib_full),
    .wt_wdata    (wt_wdata),
    .wt_push     (wt_push),
    .wt_full     (wt_full),
    .ob_rdata    (ob_rdata),
    .ob_pop      (ob_pop),
    .ob_empty    (ob_empty),
    .ctrl_start  (ctrl_start),
    .ctrl_opcode (ctrl_opcode),
    .imc_busy    (imc_busy),
    .buf_flags   (buf_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // One complete transfer. hold = number of EXEC cycles the targeted
  // buffer stays full/empty before releasing.
  task automatic xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                      input logic [3:0] s, input int hold);
    logic [31:0] exp_rd, got_rd, got_ib, got_wt;
    int exp_ib, exp_wt, exp_pop, exp_start, exp_lat;
    int n_ib, n_wt, n_pop, n_start, k;
    bit stalls, to, leak, acked;
    exp_rd = 32'd0; exp_ib = 0; exp_wt = 0; exp_pop = 0; exp_start = 0; stalls = 1'b0;
    got_rd = 32'd0; got_ib = 32'd0; got_wt = 32'd0;
    n_ib = 0; n_wt = 0; n_pop = 0; n_start = 0;
    case (off)
      8'h00: begin
        if (w) begin
          if (s[0]) begin
            opcode_m  = d[3:1];
            exp_start = int'(d[0]);
          end
        end else exp_rd = {28'd0, opcode_m, imc_busy};
      end
      8'h04: begin
        if (w) err_m = 1'b0;
        else exp_rd = {22'd0, err_m, imc_busy, buf_flags};
      end
      8'h08: if (w) begin exp_ib = 1; stalls = 1'b1; end
      8'h0C: if (w) begin exp_wt = 1; stalls = 1'b1; end
      8'h10: if (!w) begin exp_pop = 1; exp_rd = ob_rdata; stalls = 1'b1; end
      default: ;
    endcase
    to = stalls && TO_EN && (hold >= TO);
    if (to) begin
      exp_ib = 0; exp_wt = 0; exp_pop = 0;
      exp_rd = w ? 32'd0 : ERR_WORD;
      err_m = 1'b1;
      exp_lat = TO + 1;
    end else exp_lat = stalls ? hold + 2 : 2;

    cyc = 1'b1; stb = 1'b1; we = w; adr = {24'h300000, off}; wdat = d; sel = s;
    ib_full = (hold > 0); wt_full = (hold > 0); ob_empty = (hold > 0);
    k = 0; acked = 1'b0; leak = 1'b0;
    while (!acked && k < hold + 80) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (k > hold) begin ib_full = 1'b0; wt_full = 1'b0; ob_empty = 1'b0; end
      #1;
      if (ib_push) begin n_ib++; got_ib = ib_wdata; end
      if (wt_push) begin n_wt++; got_wt = wt_wdata; end
      if (ob_pop) n_pop++;
      if (ctrl_start) n_start++;
      if (ack) begin acked = 1'b1; got_rd = rdat; end
      else if (rdat != 32'd0) leak = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    ib_full = 1'b0; wt_full = 1'b0; ob_empty = 1'b0;
    chk("acked", 32'(acked), 32'd1);
    chk("latency", k, exp_lat);
    chk("rdata", got_rd, exp_rd);
    chk("ib_push_cnt", n_ib, exp_ib);
    chk("wt_push_cnt", n_wt, exp_wt);
    chk("ob_pop_cnt", n_pop, exp_pop);
    chk("start_cnt", n_start, exp_start);
    chk("dat_zero_noack", 32'(leak), 32'd0);
    if (exp_ib == 1) chk("ib_wdata", got_ib, d);
    if (exp_wt == 1) chk("wt_wdata", got_wt, d);
    tick();
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("opcode", 32'(ctrl_opcode), 32'(opcode_m));
  endtask

  // Watchdog so the run always ends
  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] offs [8];
    int n_a, n_p;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFC};
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    ib_full = 1'b0; wt_full = 1'b0; ob_empty = 1'b0; ob_rdata = 32'd0;
    imc_busy = 1'b0; buf_flags = 8'h00;
    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_strobes", {28'd0, ib_push, wt_push, ob_pop, ctrl_start}, 32'd0);
    chk("rst_opcode", 32'(ctrl_opcode), 32'd0);
    chk("rst_wdata", ib_wdata | wt_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // Directed transfers
    xfer(1'b1, 8'h08, 32'h1234_5678, 4'hF, 0);
    xfer(1'b1, 8'h0C, 32'h0BAD_F00D, 4'hF, 10);
    ob_rdata = 32'hCAFE_0001;
    xfer(1'b0, 8'h10, 32'd0, 4'hF, 0);
    buf_flags = 8'hA5; imc_busy = 1'b1;
    xfer(1'b0, 8'h04, 32'd0, 4'hF, 0);
    xfer(1'b1, 8'h00, 32'h0000_0007, 4'hF, 0);
    xfer(1'b1, 8'h00, 32'h0000_000B, 4'hE, 0);
    xfer(1'b0, 8'h00, 32'd0, 4'hF, 0);
    xfer(1'b0, 8'h08, 32'd0, 4'hF, 0);
    xfer(1'b1, 8'h10, 32'h5555_AAAA, 4'hF, 0);

    // Out-of-window request is never acked
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_1000; wdat = 32'h1; sel = 4'hF;
    n_a = 0; n_p = 0;
    repeat (20) begin
      tick();
      if (ack) n_a++;
      if (ib_push | wt_push | ob_pop | ctrl_start) n_p++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("oor_ack", n_a, 0);
    chk("oor_strobe", n_p, 0);
    tick();

    // Abort during a stalled push
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_000C; wdat = 32'h7777_0000; wt_full = 1'b1;
    repeat (4) tick();
    cyc = 1'b0; stb = 1'b0; #1;
    n_a = 0; n_p = 0;
    if (wt_push) n_p++;
    wt_full = 1'b0;
    repeat (5) begin
      tick();
      if (ack) n_a++;
      if (wt_push | ib_push | ob_pop) n_p++;
    end
    chk("abort_ack", n_a, 0);
    chk("abort_push", n_p, 0);
    xfer(1'b1, 8'h0C, 32'h0000_0042, 4'hF, 0);

    // Asynchronous reset in the middle of a stalled EXEC
    chk("op_pre_rst", 32'(ctrl_opcode), 32'(opcode_m));
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_000C; wdat = 32'h9999_0000; wt_full = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_opcode", 32'(ctrl_opcode), 32'd0);
    chk("mid_rst_ack_dat", {31'd0, ack} | rdat, 32'd0);
    chk("mid_rst_strobes", {28'd0, ib_push, wt_push, ob_pop, ctrl_start}, 32'd0);
    opcode_m = 3'd0; err_m = 1'b0;
    cyc = 1'b0; stb = 1'b0; wt_full = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    xfer(1'b0, 8'h00, 32'd0, 4'hF, 0);

`ifdef IMC_WB_TIMEOUT_EN
    // Stuck-empty output buffer times out with the error word
    ob_rdata = 32'h1111_2222;
    xfer(1'b0, 8'h10, 32'd0, 4'hF, 1000);
    xfer(1'b0, 8'h04, 32'd0, 4'hF, 0);
    xfer(1'b1, 8'h04, 32'd0, 4'hF, 0);
    xfer(1'b0, 8'h04, 32'd0, 4'hF, 0);
`endif

    // Randomized transfers against the model
    for (int i = 0; i < 60; i++) begin
      imc_busy  = 1'($urandom);
      buf_flags = 8'($urandom);
      ob_rdata  = $urandom;
      xfer(1'($urandom), offs[$urandom_range(0, 7)], $urandom,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
